// File: rtl/dbg_run_ctl_if.sv
// Host/CPU-side signal bundle for the debug run controller.
// The master drives commands and CPU observation inputs. The slave returns the run controls and status.
interface dbg_run_ctl_if #(
  parameter int PC_W   = 12,
  parameter int NUM_BP = 2,
  parameter int CYC_W  = 16
);
  logic                     cmd_valid;
  logic [1:0]               cmd_op;
  logic [7:0]               cmd_step_cnt;
  logic [NUM_BP-1:0]        bp_en;
  logic [NUM_BP*PC_W-1:0]   bp_addr;
  logic                     cpu_rst;
  logic [PC_W-1:0]          pc;
  logic                     instr_done;
  logic                     cpu_en;
  logic [1:0]               run_state;
  logic                     halt_pend;
  logic [NUM_BP-1:0]        bp_hit;
  logic [CYC_W-1:0]         cycle_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_step_cnt, bp_en, bp_addr, cpu_rst, pc, instr_done,
    input  cpu_en, run_state, halt_pend, bp_hit, cycle_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_step_cnt, bp_en, bp_addr, cpu_rst, pc, instr_done,
    output cpu_en, run_state, halt_pend, bp_hit, cycle_cnt
  );
endinterface

// File: rtl/dbg_run_ctl.sv
// Debug run controller for the MCS-4 CPU.
// Provides run, halt-at-boundary, N-step and PC breakpoints through a registered clock enable.
module dbg_run_ctl #(
  parameter int PC_W   = 12,
  parameter int NUM_BP = 2,
  parameter int CYC_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  dbg_run_ctl_if.slave  dbg
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [7:0]         step_cnt_r, step_nxt_s, step_load_s;
  logic               halt_pend_r, pend_nxt_s;
  logic [NUM_BP-1:0]  bp_hit_r, match_s;
  logic [CYC_W-1:0]   cycle_cnt_r;
  logic               cpu_en_r;
  logic               retire_s, match_any_s;
  logic               cmd_run_s, cmd_halt_s, cmd_step_s, cmd_clr_s;

  // Command decode, retire qualification and breakpoint comparators
  always_comb begin
    cmd_run_s   = dbg.cmd_valid && (dbg.cmd_op == 2'd0);
    cmd_halt_s  = dbg.cmd_valid && (dbg.cmd_op == 2'd1);
    cmd_step_s  = dbg.cmd_valid && (dbg.cmd_op == 2'd2);
    cmd_clr_s   = dbg.cmd_valid && (dbg.cmd_op == 2'd3);
    step_load_s = (dbg.cmd_step_cnt == 8'd0) ? 8'd1 : dbg.cmd_step_cnt;
    retire_s    = dbg.instr_done && !dbg.cpu_rst && cpu_en_r;
    match_s     = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match_s[i] = retire_s && dbg.bp_en[i] &&
                   (dbg.pc == dbg.bp_addr[i*PC_W +: PC_W]);
    end
    match_any_s = |match_s;
  end

  // Next-state logic: a stop on a retire outranks any coincident command
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_cnt_r;
    pend_nxt_s  = halt_pend_r;
    case (state_r)
      ST_RUN, ST_STEP: begin
        if (match_any_s) begin
          state_nxt_s = ST_BRK;
          pend_nxt_s  = 1'b0;
          step_nxt_s  = 8'd0;
        end else if (retire_s &&
                     (halt_pend_r || ((state_r == ST_STEP) && (step_cnt_r == 8'd1)))) begin
          state_nxt_s = ST_HALT;
          pend_nxt_s  = 1'b0;
          step_nxt_s  = 8'd0;
        end else begin
          if ((state_r == ST_STEP) && retire_s) begin
            step_nxt_s = step_cnt_r - 8'd1;
          end else begin
            step_nxt_s = step_cnt_r;
          end
          if (cmd_halt_s) begin
            pend_nxt_s = 1'b1;
          end else begin
            pend_nxt_s = halt_pend_r;
          end
          if (cmd_run_s && (state_r == ST_STEP)) begin
            state_nxt_s = ST_RUN;
            step_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      ST_HALT, ST_BRK: begin
        pend_nxt_s = 1'b0;
        if (cmd_run_s) begin
          state_nxt_s = ST_RUN;
        end else if (cmd_step_s) begin
          state_nxt_s = ST_STEP;
          step_nxt_s  = step_load_s;
        end else if (cmd_halt_s || cmd_clr_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_HALT;
        pend_nxt_s  = 1'b0;
        step_nxt_s  = 8'd0;
      end
    endcase
  end

  // State, status and clock-enable registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_HALT;
      step_cnt_r  <= 8'd0;
      halt_pend_r <= 1'b0;
      bp_hit_r    <= '0;
      cycle_cnt_r <= '0;
      cpu_en_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      step_cnt_r  <= step_nxt_s;
      halt_pend_r <= pend_nxt_s;
      cpu_en_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STEP);
      // current-cycle hits survive a coincident clear
      bp_hit_r    <= (cmd_clr_s ? '0 : bp_hit_r) | match_s;
      if (cmd_clr_s) begin
        cycle_cnt_r <= '0;
      end else if (cpu_en_r && !dbg.cpu_rst && (cycle_cnt_r != {CYC_W{1'b1}})) begin
        cycle_cnt_r <= cycle_cnt_r + CYC_W'(1);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
    end
  end

  assign dbg.cpu_en    = cpu_en_r;
  assign dbg.run_state = state_r;
  assign dbg.halt_pend = halt_pend_r;
  assign dbg.bp_hit    = bp_hit_r;
  assign dbg.cycle_cnt = cycle_cnt_r;

endmodule
